// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Push-button front end: synchronizes the raw button pins, debounces each
//   one against a shared sample tick, and produces a one-clk press pulse per
//   button. Buttons selected by REPEAT_MASK also auto-repeat while held.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, ACTIVE LOW
//   btn_in     raw asynchronous button pins, active-high ([3]=L [2]=R [1]=U [0]=D)
//   btn_level  debounced level per button (registered)
//   btn_pulse  one-clk press / repeat pulse per button (registered)

// Per-button debounce + press/repeat FSM.
// Debounce runs on tick edges. The FSM runs one clk later, on tick_d edges,
// so it sees the level that the tick edge just produced.
module btn_lane #(
    parameter int STABLE_CNT   = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic tick,
    input  logic tick_d,
    output logic level,
    output logic pulse
);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t      state;
    logic [7:0]  scnt;
    logic [15:0] rcnt;
    logic [7:0]  scnt_inc;
    logic [15:0] rcnt_inc;

    assign scnt_inc = scnt + 8'd1;
    assign rcnt_inc = rcnt + 16'd1;

    // Any sample that agrees with the current level restarts the count,
    // so only STABLE_CNT consecutive disagreeing samples flip the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt  <= '0;
            level <= 1'b0;
        end else if (tick) begin
            if (sample == level) begin
                scnt <= '0;
            end else if (scnt_inc == 8'(STABLE_CNT)) begin
                level <= ~level;
                scnt  <= '0;
            end else begin
                scnt <= scnt_inc;
            end
        end
    end

    // A release takes priority over an rcnt match evaluated in the same step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (tick_d) begin
                case (state)
                    IDLE: begin
                        if (level) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                            state <= HELD;
                        end
                    end
                    HELD: begin
                        if (!level) begin
                            state <= IDLE;
                        end else if (REPEAT_EN) begin
                            if (rcnt_inc == 16'(REPEAT_DELAY)) begin
                                pulse <= 1'b1;
                                rcnt  <= '0;
                                state <= REPEAT;
                            end else begin
                                rcnt <= rcnt_inc;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!level) begin
                            state <= IDLE;
                        end else if (rcnt_inc == 16'(REPEAT_RATE)) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

module btn_conditioner #(
    parameter int             N_BTN        = 4,
    parameter int             SAMPLE_DIV   = 100_000,
    parameter int             STABLE_CNT   = 8,
    parameter int             REPEAT_DELAY = 500,
    parameter int             REPEAT_RATE  = 100,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [TW-1:0]    tcnt;
    logic             tick;
    logic             tick_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Shared sample tick: high for the single cycle where tcnt is at its top.
    assign tick = (tcnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt   <= '0;
            tick_d <= 1'b0;
        end else begin
            tcnt   <= tick ? '0 : tcnt + TW'(1);
            tick_d <= tick;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        btn_lane #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_EN   (REPEAT_MASK[g])
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .sample(sync2[g]),
            .tick  (tick),
            .tick_d(tick_d),
            .level (btn_level[g]),
            .pulse (btn_pulse[g])
        );
    end

endmodule
